// File: rtl/trig_route_seq_if.sv
// trig_route_seq_if: routing request, trigger lines and panel/ICX control bundle.
interface trig_route_seq_if;
  logic [2:0] route_req;
  logic trig, trig_from_FP, trig_from_BP, cnt_clr;
  logic trig_t_FP, trig_t_BP, trig_FP_sel, trig_BP_sel;
  logic [1:0] trig_ICX_sel;
  logic [2:0] route_cur;
  logic busy, drain_tmo;
  logic [31:0] trig_cnt;
  modport master (
    output route_req, trig, trig_from_FP, trig_from_BP, cnt_clr,
    input trig_t_FP, trig_t_BP, trig_FP_sel, trig_BP_sel, trig_ICX_sel, route_cur, busy, drain_tmo, trig_cnt
  );
  modport slave (
    input route_req, trig, trig_from_FP, trig_from_BP, cnt_clr,
    output trig_t_FP, trig_t_BP, trig_FP_sel, trig_BP_sel, trig_ICX_sel, route_cur, busy, drain_tmo, trig_cnt
  );
endinterface

// File: rtl/trig_route_seq.sv
// trig_route_seq: break-before-make trigger routing change (drain, dead time, select, settle, drive).
// Define TRIG_ROUTE_CNT_EN to add a counter of rising edges on the ICX-selected trigger source.
module trig_route_seq #(
  parameter int DEAD_CYC = 8,
  parameter int SETTLE_CYC = 4,
  parameter int DRAIN_TMO = 255
) (
  input logic wb_clk,
  input logic wb_rst_n,
  trig_route_seq_if.slave bus
);
  typedef enum logic [2:0] {IDLE, DRAIN, DEAD, APPLY, SETTLE} state_t;
  state_t state;
  logic [7:0] cnt;
  logic [2:0] route_new, route_cur;
  logic t_fp, t_bp, fp_sel, bp_sel, busy, drain_tmo;
  logic [1:0] icx_sel;
  logic quiet, new_fp_drv, new_bp_drv;
  logic [1:0] new_icx;
  assign quiet = ~(bus.trig | bus.trig_from_FP | bus.trig_from_BP);
  assign new_fp_drv = route_new == 3'b001 || route_new == 3'b011 || route_new == 3'b111;
  assign new_bp_drv = route_new == 3'b010 || route_new == 3'b011 || route_new == 3'b101;
  assign new_icx = route_new[2] ? (route_new[1] ? 2'd2 : 2'd1) : 2'd0;
  always_ff @(posedge wb_clk or negedge wb_rst_n)
    if (!wb_rst_n) begin
      state <= IDLE;
      cnt <= '0;
      route_new <= '0;
      route_cur <= '0;
      t_fp <= 1'b1;
      t_bp <= 1'b1;
      fp_sel <= 1'b0;
      bp_sel <= 1'b0;
      icx_sel <= 2'd0;
      busy <= 1'b0;
      drain_tmo <= 1'b0;
    end else begin
      drain_tmo <= 1'b0;
      case (state)
        IDLE: if (bus.route_req != route_cur) begin
          route_new <= bus.route_req;
          state <= DRAIN;
          cnt <= '0;
          t_fp <= 1'b1;
          t_bp <= 1'b1;
          icx_sel <= 2'd3;
          busy <= 1'b1;
        end
        DRAIN: if (quiet || cnt == 8'(DRAIN_TMO - 1)) begin
          drain_tmo <= ~quiet;
          state <= DEAD;
          cnt <= '0;
        end else cnt <= cnt + 8'd1;
        // an undriven panel keeps whatever select it had
        DEAD: if (cnt == 8'(DEAD_CYC - 1)) begin
          state <= APPLY;
          cnt <= '0;
          if (new_fp_drv) fp_sel <= route_new == 3'b111;
          if (new_bp_drv) bp_sel <= route_new == 3'b101;
        end else cnt <= cnt + 8'd1;
        APPLY: state <= SETTLE;
        SETTLE: if (cnt == 8'(SETTLE_CYC - 1)) begin
          state <= IDLE;
          cnt <= '0;
          t_fp <= ~new_fp_drv;
          t_bp <= ~new_bp_drv;
          icx_sel <= new_icx;
          route_cur <= route_new;
          busy <= 1'b0;
        end else cnt <= cnt + 8'd1;
        default: state <= IDLE;
      endcase
    end
  assign bus.trig_t_FP = t_fp;
  assign bus.trig_t_BP = t_bp;
  assign bus.trig_FP_sel = fp_sel;
  assign bus.trig_BP_sel = bp_sel;
  assign bus.trig_ICX_sel = icx_sel;
  assign bus.route_cur = route_cur;
  assign bus.busy = busy;
  assign bus.drain_tmo = drain_tmo;
`ifdef TRIG_ROUTE_CNT_EN
  logic [2:0] prev;
  logic [31:0] trig_cnt;
  logic rise;
  assign rise = icx_sel == 2'd0 ? bus.trig & ~prev[0] :
                icx_sel == 2'd1 ? bus.trig_from_FP & ~prev[1] :
                icx_sel == 2'd2 ? bus.trig_from_BP & ~prev[2] : 1'b0;
  always_ff @(posedge wb_clk or negedge wb_rst_n)
    if (!wb_rst_n) begin
      prev <= '0;
      trig_cnt <= '0;
    end else begin
      prev <= {bus.trig_from_BP, bus.trig_from_FP, bus.trig};
      trig_cnt <= bus.cnt_clr ? '0 : trig_cnt + 32'(rise);
    end
  assign bus.trig_cnt = trig_cnt;
`else
  assign bus.trig_cnt = '0;
`endif
endmodule
